// File: rtl/router_pkg.sv
// Shared router types and default geometry for the output-VC tracking logic.
package router_pkg;

  localparam int unsigned ROUTER_NUM_PORTS = 5;
  localparam int unsigned ROUTER_NUM_VC    = 4;
  localparam int unsigned ROUTER_BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ACTIVE = 2'd1,
    VC_DRAIN  = 2'd2
  } vc_state_e;

endpackage

// File: rtl/output_vc_slot.sv
// One output VC: allocation state plus downstream credit counter.
module output_vc_slot
  import router_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = ROUTER_BUF_DEPTH,
  parameter int unsigned CRED_BITS = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_i,
  input  logic                 send_i,
  input  logic                 tail_i,
  input  logic                 credit_i,
  output logic                 avail_o,
  output logic                 credit_ok_o,
  output logic [CRED_BITS-1:0] count_o,
  output logic                 err_o
);

  localparam logic [CRED_BITS-1:0] FULL = CRED_BITS'(BUF_DEPTH);

  vc_state_e              state_q, state_d;
  logic [CRED_BITS-1:0]   cnt_q, cnt_d;
  logic                   send_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= VC_IDLE;
      cnt_q   <= FULL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_o   = 1'b0;

    // An alloc+send to an IDLE VC sees state_q==IDLE, so the send is rejected here.
    send_ok = send_i && (state_q == VC_ACTIVE) && (cnt_q != '0);
    if (send_i && !send_ok)                 err_o = 1'b1;
    if (alloc_i && (state_q != VC_IDLE))    err_o = 1'b1;

    unique case ({send_ok, credit_i})
      2'b10: cnt_d = cnt_q - CRED_BITS'(1);
      2'b01: begin
        if (cnt_q == FULL) err_o = 1'b1;
        else               cnt_d = cnt_q + CRED_BITS'(1);
      end
      default: cnt_d = cnt_q;
    endcase

    unique case (state_q)
      VC_IDLE:   if (alloc_i)           state_d = VC_ACTIVE;
      VC_ACTIVE: if (send_ok && tail_i) state_d = VC_DRAIN;
      VC_DRAIN:  if (cnt_d == FULL)     state_d = VC_IDLE;
      default:                          state_d = VC_IDLE;
    endcase
  end

  assign avail_o     = (state_q == VC_IDLE);
  assign credit_ok_o = (state_q == VC_ACTIVE) && (cnt_q != '0);
  assign count_o     = cnt_q;

endmodule

// File: rtl/output_vc_tracker.sv
// Tracks allocation state and downstream credits for every output VC of a router.
module output_vc_tracker
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int unsigned NUM_VC    = ROUTER_NUM_VC,
  parameter int unsigned BUF_DEPTH = ROUTER_BUF_DEPTH,
  parameter int unsigned VC_BITS   = $clog2(NUM_VC),
  parameter int unsigned CRED_BITS = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_PORTS*NUM_VC-1:0]                vc_alloc,
  input  logic [NUM_PORTS-1:0]                       send_valid,
  input  logic [NUM_PORTS-1:0][VC_BITS-1:0]          send_vc,
  input  logic [NUM_PORTS-1:0]                       send_tail,
  input  logic [NUM_PORTS-1:0]                       credit_valid,
  input  logic [NUM_PORTS-1:0][VC_BITS-1:0]          credit_vc,
  output logic [NUM_PORTS*NUM_VC-1:0]                vc_availability,
  output logic [NUM_PORTS*NUM_VC-1:0]                credit_ok,
  output logic [NUM_PORTS*NUM_VC-1:0][CRED_BITS-1:0] credit_count,
  output logic                                       protocol_error
);

  localparam int unsigned NSLOT = NUM_PORTS * NUM_VC;

  logic [NSLOT-1:0] send_dec;
  logic [NSLOT-1:0] credit_dec;
  logic [NSLOT-1:0] slot_err;
  logic             err_q, err_d;

  always_comb begin
    send_dec   = '0;
    credit_dec = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        send_dec[p*NUM_VC+v]   = send_valid[p]   && (send_vc[p]   == VC_BITS'(v));
        credit_dec[p*NUM_VC+v] = credit_valid[p] && (credit_vc[p] == VC_BITS'(v));
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      output_vc_slot #(
        .BUF_DEPTH (BUF_DEPTH),
        .CRED_BITS (CRED_BITS)
      ) u_slot (
        .clk_i       (clk),
        .rst_ni      (reset),
        .alloc_i     (vc_alloc[p*NUM_VC+v]),
        .send_i      (send_dec[p*NUM_VC+v]),
        .tail_i      (send_tail[p]),
        .credit_i    (credit_dec[p*NUM_VC+v]),
        .avail_o     (vc_availability[p*NUM_VC+v]),
        .credit_ok_o (credit_ok[p*NUM_VC+v]),
        .count_o     (credit_count[p*NUM_VC+v]),
        .err_o       (slot_err[p*NUM_VC+v])
      );
    end
  end

  assign err_d = err_q | (|slot_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign protocol_error = err_q;

endmodule

// File: doc/output_vc_tracker.md
OUTPUT_VC_TRACKER -- requirements
Module: output_vc_tracker

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of router ports.
REQ-002 SHALL have parameter NUM_VC, default 4, VCs per port.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, downstream buffer slots per VC.
REQ-004 SHALL have derived parameters VC_BITS = $clog2(NUM_VC) and CRED_BITS = $clog2(BUF_DEPTH+1).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port vc_alloc, input, NUM_PORTS*NUM_VC, per-output-VC allocation pulse from the VC allocator.
REQ-008 SHALL have port send_valid, input, NUM_PORTS, flit leaves the output port this cycle.
REQ-009 SHALL have port send_vc, input, VC_BITS x [NUM_PORTS], output VC of the sent flit.
REQ-010 SHALL have port send_tail, input, NUM_PORTS, sent flit is a tail (including head+tail).
REQ-011 SHALL have port credit_valid, input, NUM_PORTS, downstream credit return.
REQ-012 SHALL have port credit_vc, input, VC_BITS x [NUM_PORTS], VC of the returned credit.
REQ-013 SHALL have port vc_availability, output, NUM_PORTS*NUM_VC, output VC free for allocation; feeds the VC allocator.
REQ-014 SHALL have port credit_ok, output, NUM_PORTS*NUM_VC, output VC ACTIVE with credits > 0; gates switch allocation.
REQ-015 SHALL have port credit_count, output, CRED_BITS x [NUM_PORTS*NUM_VC], current credits.
REQ-016 SHALL have port protocol_error, output, 1, sticky error flag.

Function
REQ-017 SHALL index every flat vector as port*NUM_VC + vc.
REQ-018 SHALL keep, per output VC, a state (IDLE, ACTIVE or DRAIN) and a credit counter in the range 0..BUF_DEPTH.
REQ-019 SHALL move IDLE->ACTIVE on vc_alloc; vc_availability falls one cycle later.
REQ-020 SHALL move ACTIVE->DRAIN on a valid send with send_tail to that VC.
REQ-021 SHALL move DRAIN->IDLE in the cycle the post-update credit count equals BUF_DEPTH; vc_availability rises one cycle later.
REQ-022 SHALL decrement credits on a valid send and increment them on a valid credit; both in the same cycle to the same VC SHALL leave the count unchanged.
REQ-023 SHALL assert vc_availability only in IDLE and credit_ok only in ACTIVE with count > 0.
REQ-024 SHALL drive all outputs from registered state only, with no input-to-output combinational path.
REQ-025 SHALL ignore vc_alloc to a non-IDLE VC and set protocol_error.
REQ-026 SHALL ignore a send to an IDLE or DRAIN VC, or to a VC with count 0, and set protocol_error.
REQ-027 SHALL saturate the count at BUF_DEPTH on an overflowing credit and set protocol_error.
REQ-028 SHALL process sends and credits on different ports independently in the same cycle.
REQ-029 SHALL apply vc_alloc and a send to the same IDLE VC in the same cycle as follows: the allocation takes effect and the send is an error.

Reset
REQ-030 SHALL, on reset low, immediately set every VC to IDLE with count BUF_DEPTH, irrespective of the clock.
REQ-031 SHALL drive vc_availability to all ones, credit_ok to all zeros, every credit_count to BUF_DEPTH and protocol_error to 0 while in reset.
REQ-032 SHALL make reset mid-packet discard all state with no error.
REQ-033 SHALL clear protocol_error only by reset.

Structure
REQ-034 SHALL place the enum vc_state_e (VC_IDLE, VC_ACTIVE, VC_DRAIN) and the default NUM_PORTS, NUM_VC and BUF_DEPTH in a shared package, router_pkg.
REQ-035 SHALL implement per-VC state and counter in one sub-module, output_vc_slot, instantiated NUM_PORTS*NUM_VC times.
REQ-036 SHALL decode send_vc and credit_vc per port in the top level, with the error flags OR-reduced there.

Verification
REQ-037 SHALL cover: reset release -> vc_availability=20'hFFFFF, all counts 4, credit_ok=0.
REQ-038 SHALL cover: vc_alloc bit 6 (port1, vc2) -> next cycle avail[6]=0, credit_ok[6]=1; 4 sends -> count 0, credit_ok[6]=0.
REQ-039 SHALL cover: port1 vc2 sending a 3-flit packet (tail on 3rd) -> DRAIN; 2 credits -> still DRAIN; 3rd credit -> avail[6]=1 the next cycle.
REQ-040 SHALL cover: simultaneous send and credit on port0 vc0 at count 2 -> count stays 2.
REQ-041 SHALL cover: a credit to IDLE port4 vc3 -> count 4 (saturated), protocol_error=1 and stays 1 until reset.
REQ-042 SHALL cover: reset asserted mid-packet on port2 vc1 at count 1 -> immediately IDLE, count 4, avail[9]=1.
